// File: rtl/mips_registers_16_pkg.sv
// Shared MIPS16 constants: datapath width, register count, register-address
// width and the index of the hard-wired zero register. Also provides the
// depth helper used to map heap-ordered mux-tree nodes to address bits.
package mips_registers_16_pkg;

  localparam int unsigned MIPS16_DATA_W   = 16;
  localparam int unsigned MIPS16_NREG     = 8;
  localparam int unsigned MIPS16_ADDR_W   = 3;
  localparam int unsigned MIPS16_REG_ZERO = 0;

  // Depth of node k in a heap-ordered binary tree (root = node 0):
  // floor(log2(k+1)).
  function automatic int unsigned tree_depth(input int unsigned k);
    return int'($clog2(k + 2)) - 1;
  endfunction

endpackage

// File: rtl/mips_registers_16_register16.sv
// Register-file building blocks.
//   register16 : DATA_W-bit D register, synchronous active-high reset,
//                load enable.
//     clk_i, reset_i, en_i, d_i -> q_o
//   mux2_16    : DATA_W-bit 2:1 multiplexer cell (sel_i=0 -> in0_i).
//     in0_i, in1_i, sel_i -> y_o
module register16 #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

module mux2_16 #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mips_registers_16.sv
// MIPS16 architectural register file.
//   Two combinational read ports (no write-through: a same-cycle write to the
//   read address is visible only after the edge), one synchronous write port.
//   Register 0 always reads zero. Synchronous active-high reset clears all.
// Ports:
//   clk, reset            clock, synchronous reset
//   reg_write             write enable
//   read_reg1/read_reg2   read addresses (rs / rt)
//   write_reg/write_data  write address and data
//   read_data1/read_data2 read data
module mips_registers_16
  import mips_registers_16_pkg::*;
#(
  parameter int unsigned DATA_W = MIPS16_DATA_W,
  parameter int unsigned NREG   = MIPS16_NREG,
  parameter int unsigned ADDR_W = MIPS16_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [NREG-1:0]   load_en;
  logic [DATA_W-1:0] regs_q   [NREG];
  logic [DATA_W-1:0] rd1_node [2*NREG-1];
  logic [DATA_W-1:0] rd2_node [2*NREG-1];

  // Address decode gated by reg_write; the zero register never loads.
  always_comb begin
    load_en = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (i != MIPS16_REG_ZERO) begin
        load_en[i] = reg_write && (write_reg == ADDR_W'(i));
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    register16 #(.W(DATA_W)) u_reg (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (load_en[g]),
      .d_i     (write_data),
      .q_o     (regs_q[g])
    );

    // Leaves of the read trees; the zero register is hard-wired so it reads
    // zero even before the first reset.
    if (g == MIPS16_REG_ZERO) begin : g_leaf_zero
      assign rd1_node[NREG-1+g] = '0;
      assign rd2_node[NREG-1+g] = '0;
    end else begin : g_leaf
      assign rd1_node[NREG-1+g] = regs_q[g];
      assign rd2_node[NREG-1+g] = regs_q[g];
    end
  end

  // Read muxes as heap-ordered trees of 2:1 cells: node k takes children
  // 2k+1 (bit=0) and 2k+2 (bit=1); the root level decodes the address MSB.
  for (genvar k = 0; k < NREG - 1; k++) begin : g_mux
    localparam int unsigned SEL_BIT = ADDR_W - 1 - tree_depth(k);

    mux2_16 #(.W(DATA_W)) u_mux1 (
      .in0_i (rd1_node[2*k+1]),
      .in1_i (rd1_node[2*k+2]),
      .sel_i (read_reg1[SEL_BIT]),
      .y_o   (rd1_node[k])
    );

    mux2_16 #(.W(DATA_W)) u_mux2 (
      .in0_i (rd2_node[2*k+1]),
      .in1_i (rd2_node[2*k+2]),
      .sel_i (read_reg2[SEL_BIT]),
      .y_o   (rd2_node[k])
    );
  end

  assign read_data1 = rd1_node[0];
  assign read_data2 = rd2_node[0];

endmodule

// File: tb/tb_mips_registers_16.sv
// Self-checking bench for mips_registers_16: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against an array
// model of the register file.
module tb_mips_registers_16;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_write;
  logic [AW-1:0] read_reg1, read_reg2, write_reg;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data1, read_data2;

  always #5 clk = ~clk;

  mips_registers_16 #(
    .DATA_W (DW),
    .NREG   (NR),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] model [NR];
  bit            model_ok = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (a == 0) ? '0 : model[a];
  endfunction

  // Model update on the edge, from the inputs present at that edge.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < int'(NR); i++) model[i] = '0;
      model_ok = 1'b1;
    end else if (reg_write === 1'b1 && write_reg != 0) begin
      model[write_reg] = write_data;
    end
  end

  // Per-cycle compare, mid-cycle: reads reflect pre-edge state.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_rd1", read_data1, model_read(read_reg1));
      chk("model_rd2", read_data2, model_read(read_reg2));
    end
  end

  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wr,
                      input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2);
    @(posedge clk);
    #1;
    reset = rst; reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2;
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b1; write_reg = 3'd4; write_data = 16'h7777;
    read_reg1 = '0; read_reg2 = '0;

    // Reset then read every register.
    for (int r = 0; r < int'(NR); r++) begin
      step(1'b0, 1'b0, '0, '0, AW'(r), AW'(NR - 1 - r));
      @(negedge clk);
      chk("reset_rd1", read_data1, 16'h0000);
    end

    // Write BEEF to r3, read on both ports.
    step(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
    @(negedge clk);
    chk("wr_r3_rd1", read_data1, 16'hBEEF);
    chk("wr_r3_rd2", read_data2, 16'hBEEF);

    // r0 stays zero.
    step(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    @(negedge clk);
    chk("r0_protect", read_data1, 16'h0000);

    // Read during write: old value before the edge, new after.
    step(1'b0, 1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
    step(1'b0, 1'b1, 3'd5, 16'h5678, 3'd0, 3'd5);
    @(negedge clk);
    chk("rdw_before", read_data2, 16'h1234);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5);
    @(negedge clk);
    chk("rdw_after", read_data2, 16'h5678);
    chk("rdw_same_addr", read_data1, 16'h5678);

    // Reset wins over a simultaneous write.
    step(1'b0, 1'b1, 3'd7, 16'h1111, 3'd7, 3'd7);
    step(1'b1, 1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd7);
    @(negedge clk);
    chk("pre_reset_r7", read_data1, 16'h1111);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd3);
    @(negedge clk);
    chk("reset_prio_r7", read_data1, 16'h0000);
    chk("reset_clears_r3", read_data2, 16'h0000);

    // Write disable, including unknown data while disabled.
    step(1'b0, 1'b1, 3'd2, 16'hC0DE, 3'd0, 3'd0);
    step(1'b0, 1'b0, 3'd2, 16'h00FF, 3'd2, 3'd2);
    step(1'b0, 1'b0, 3'd2, 16'hxxxx, 3'd2, 3'd1);
    @(negedge clk);
    chk("wr_disable_r2", read_data1, 16'hC0DE);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd0);
    @(negedge clk);
    chk("wr_disable_x_r2", read_data1, 16'hC0DE);

    // Randomized traffic checked by the per-cycle compare.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           AW'($urandom_range(0, NR - 1)),
           DW'($urandom),
           AW'($urandom_range(0, NR - 1)),
           AW'($urandom_range(0, NR - 1)));
    end

    step(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mips_registers_16.md
MIPS_REGISTERS_16 -- requirements
Module: mips_registers_16

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, as the register and data-bus width in bits.
REQ-002 The block SHALL have parameter NREG, default 8, as the number of architectural registers.
REQ-003 The block SHALL have parameter ADDR_W, default 3, as the register-address width, equal to log2(NREG).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-006 reg_write  input  1  write enable from the main control unit.
REQ-007 read_reg1  input  ADDR_W  source register rs address.
REQ-008 read_reg2  input  ADDR_W  source register rt address.
REQ-009 write_reg  input  ADDR_W  destination address, driven by the RegDst 2:1 selection.
REQ-010 write_data  input  DATA_W  writeback value, driven by the MemtoReg 16-bit 2:1 selection.
REQ-011 read_data1  output  DATA_W  contents of register read_reg1; feeds the ALU A input.
REQ-012 read_data2  output  DATA_W  contents of register read_reg2; feeds the ALUSrc 16-bit 2:1 selection as in0 and the data-memory write data.

Function
REQ-013 Reads SHALL be combinational with zero-cycle latency: read_dataN SHALL reflect the addressed register's current state within the same cycle.
REQ-014 Register 0 SHALL always read 16'h0000, whatever writes are attempted.
REQ-015 On a rising clk edge with reset=0, reg_write=1 and write_reg!=0, register[write_reg] SHALL load write_data.
REQ-016 An edge with reg_write=0, or with write_reg=0, SHALL leave every register unchanged.
REQ-017 During a cycle that writes address A, a read of A SHALL return the pre-write value; the new value SHALL appear only after the edge (no write-through bypass).
REQ-018 read_reg1 equal to read_reg2 SHALL return identical data on both ports.
REQ-019 Exactly one register SHALL change per edge at most; registers not addressed SHALL hold their values.
REQ-020 X or Z on write_data with reg_write=0 SHALL NOT corrupt any register.

Reset
REQ-021 On a rising clk edge with reset=1, all NREG registers SHALL become 0, so that read_data1 and read_data2 read 16'h0000 after that edge.
REQ-022 Reset SHALL take priority over a simultaneous write; the write SHALL be discarded.
REQ-023 Reset asserted mid-program SHALL take effect on the next edge only; there SHALL be no asynchronous clear path.

Structure
REQ-024 DATA_W=16, NREG=8, ADDR_W=3 and the register-index constant for register 0 SHALL live in the shared mips16 package and be reused by the control and datapath blocks.
REQ-025 Each storage element SHALL be an instance of a sub-module register16 (16-bit D register with synchronous reset and load enable).
REQ-026 Per-register load enables SHALL come from a 3-to-8 decode of write_reg, ANDed with reg_write; the register-0 enable SHALL be tied to 0.
REQ-027 Read selection SHALL be two 8:1 x 16-bit multiplexers built from the team's existing 2:1 multiplexer cells.

Verification
REQ-028 Reset then reads: reset=1 for 1 edge, then every read_reg1 value 0..7 -> read_data1=16'h0000 for all eight.
REQ-029 Write/read: write 16'hBEEF to r3 (reg_write=1, write_reg=3), next cycle read_reg1=3 -> 16'hBEEF; same cycle read_reg2=3 -> 16'hBEEF.
REQ-030 Register 0 protection: write 16'hFFFF to r0 -> read_data1 at read_reg1=0 stays 16'h0000.
REQ-031 Read-during-write: r5=16'h1234; write 16'h5678 to r5 while read_reg2=5 -> 16'h1234 before the edge, 16'h5678 after.
REQ-032 Reset priority: reset=1 and reg_write=1 writing 16'hAAAA to r7 on the same edge -> r7 reads 16'h0000.
REQ-033 Write disable: reg_write=0, write_reg=2, write_data=16'h00FF -> r2 keeps its prior value 16'hC0DE.
